// File: rtl/cam_capture_ctrl_if.sv
// Camera-side and buffer-write-side signals of cam_capture_ctrl bundled as one interface.
// test_mode exists only when CAM_TEST_PATTERN_EN is defined.
interface cam_capture_ctrl_if #(
    parameter int unsigned ADDR_W = 17
);
`ifdef CAM_TEST_PATTERN_EN
    logic              test_mode;
`endif
    logic              cam_vsync;
    logic              cam_href;
    logic [7:0]        cam_d;
    logic              cmd_toggle;
    logic              cmd_single;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [11:0]       wdata;
    logic              busy;
    logic              frame_done;
    logic              overflow;
    logic [7:0]        frame_cnt;

    modport master (
`ifdef CAM_TEST_PATTERN_EN
        output test_mode,
`endif
        output cam_vsync, cam_href, cam_d, cmd_toggle, cmd_single,
        input  we, addr, wdata, busy, frame_done, overflow, frame_cnt
    );

    modport slave (
`ifdef CAM_TEST_PATTERN_EN
        input  test_mode,
`endif
        input  cam_vsync, cam_href, cam_d, cmd_toggle, cmd_single,
        output we, addr, wdata, busy, frame_done, overflow, frame_cnt
    );
endinterface

// File: rtl/cam_capture_ctrl.sv
// OV7670 capture sequencer: frames vsync/href, packs RGB444, decimates and writes the frame buffer.
// Optional macro CAM_TEST_PATTERN_EN adds test_mode, replacing pixel data with 8 vertical colour bars.
module cam_capture_ctrl #(
    parameter int unsigned IMG_W   = 640,
    parameter int unsigned IMG_H   = 480,
    parameter int unsigned H_DECIM = 2,
    parameter int unsigned V_DECIM = 2,
    parameter int unsigned ADDR_W  = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    cam_capture_ctrl_if.slave bus
);
    localparam int unsigned OUT_W  = IMG_W / H_DECIM;
    localparam int unsigned OUT_H  = IMG_H / V_DECIM;
    localparam int unsigned LAST   = OUT_W * OUT_H - 1;
    localparam int unsigned COL_W  = $clog2(IMG_W + 1);
    localparam int unsigned LINE_W = $clog2(IMG_H + 1);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_SYNC, S_CAPTURE, S_DONE} state_e;

    state_e            state_q, state_d;
    logic              cont_q, cont_d, single_q, single_d;
    logic              vs_prev_q, href_prev_q, phase_q, phase_d;
    logic [7:0]        hi_q, hi_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [11:0]       wdata_q, wdata_d;
    logic              busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
    logic [7:0]        fcnt_q, fcnt_d;
    logic              vs_rise, vs_fall, href_fall, stop_req, qualified;
    logic [11:0]       pix;

    assign vs_rise   = bus.cam_vsync & ~vs_prev_q;
    assign vs_fall   = ~bus.cam_vsync & vs_prev_q;
    assign href_fall = ~bus.cam_href & href_prev_q;
    assign stop_req  = bus.cmd_toggle & cont_q;
    assign qualified = (32'(col_q) < IMG_W) && (32'(line_q) < IMG_H)
                    && ((32'(col_q) % H_DECIM) == 32'd0)
                    && ((32'(line_q) % V_DECIM) == 32'd0);

`ifdef CAM_TEST_PATTERN_EN
    // Bar index from the decimated column; columns past the image clamp to the last bar.
    logic [31:0] bar_raw;
    logic [2:0]  bar_idx;
    logic [11:0] bar_rgb;
    assign bar_raw = ((32'(col_q) / H_DECIM) * 32'd8) / OUT_W;
    assign bar_idx = (bar_raw > 32'd7) ? 3'd7 : bar_raw[2:0];
    always_comb begin
        bar_rgb = 12'h000;
        case (bar_idx)
            3'd0: bar_rgb = 12'hFFF;
            3'd1: bar_rgb = 12'hFF0;
            3'd2: bar_rgb = 12'h0FF;
            3'd3: bar_rgb = 12'h0F0;
            3'd4: bar_rgb = 12'hF0F;
            3'd5: bar_rgb = 12'hF00;
            3'd6: bar_rgb = 12'h00F;
            default: bar_rgb = 12'h000;
        endcase
    end
    assign pix = bus.test_mode ? bar_rgb : {hi_q, bus.cam_d[7:4]};
`else
    assign pix = {hi_q, bus.cam_d[7:4]};
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cont_d   = stop_req ? 1'b0 : cont_q;
        single_d = single_q;
        phase_d  = phase_q;
        hi_d     = hi_q;
        col_d    = col_q;
        line_d   = line_q;
        we_d     = 1'b0;
        addr_d   = we_q ? addr_q + ADDR_W'(1) : addr_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        fcnt_d   = fcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_toggle) begin
                    cont_d  = 1'b1;
                    state_d = S_ARM;
                end else if (bus.cmd_single) begin
                    single_d = 1'b1;
                    state_d  = S_ARM;
                end
            end
            S_ARM: begin
                if (stop_req)           state_d = S_IDLE;
                else if (bus.cam_vsync) state_d = S_SYNC;
            end
            S_SYNC: begin
                if (stop_req) begin
                    state_d = S_IDLE;
                end else if (vs_fall) begin
                    state_d = S_CAPTURE;
                    addr_d  = '0;
                    col_d   = '0;
                    line_d  = '0;
                    phase_d = 1'b0;
                end
            end
            S_CAPTURE: begin
                if (vs_rise) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    fcnt_d  = fcnt_q + 8'd1;
                end else if (bus.cam_href) begin
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        hi_d = bus.cam_d;
                    end else begin
                        col_d = (32'(col_q) < IMG_W) ? col_q + COL_W'(1) : col_q;
                        if (qualified) begin
                            if (32'(addr_q) > LAST) begin
                                ovf_d = 1'b1;
                            end else begin
                                we_d    = 1'b1;
                                wdata_d = pix;
                            end
                        end
                    end
                end else begin
                    // A dangling odd byte is dropped by forcing the phase back to 0.
                    phase_d = 1'b0;
                    if (href_fall) begin
                        col_d  = '0;
                        line_d = (32'(line_q) < IMG_H) ? line_q + LINE_W'(1) : line_q;
                    end
                end
            end
            S_DONE: begin
                if (cont_d) begin
                    state_d = S_SYNC;
                end else begin
                    state_d  = S_IDLE;
                    single_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_ARM) || (state_d == S_CAPTURE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cont_q      <= 1'b0;
            single_q    <= 1'b0;
            vs_prev_q   <= 1'b0;
            href_prev_q <= 1'b0;
            phase_q     <= 1'b0;
            hi_q        <= '0;
            col_q       <= '0;
            line_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            fcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            cont_q      <= cont_d;
            single_q    <= single_d;
            vs_prev_q   <= bus.cam_vsync;
            href_prev_q <= bus.cam_href;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            col_q       <= col_d;
            line_q      <= line_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            fcnt_q      <= fcnt_d;
        end
    end

    assign bus.we         = we_q;
    assign bus.addr       = addr_q;
    assign bus.wdata      = wdata_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.overflow   = ovf_q;
    assign bus.frame_cnt  = fcnt_q;
endmodule
